// File: rtl/trig_activity_monitor.sv
// Activity monitor for NCH rare trigger nodes: each node passes through a
// pipeline, and a saturating counter per node drives a sticky threshold alarm.
module trig_activity_monitor #(
    parameter int NCH   = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8,
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic [NCH-1:0]   trig_in,
    input  logic             mode_edge,
    input  logic             enable,
    input  logic [CNT_W-1:0] thresh,
    input  logic             clr,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [NCH-1:0]   alarm,
    output logic             alarm_any
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DEPTH-1:0][NCH-1:0] pipe_q;
    logic [NCH-1:0]            p_d_q;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]            alarm_q, alarm_d;
    logic                      alarm_any_q, alarm_any_d;
    logic [CNT_W-1:0]          rd_cnt_q, rd_cnt_d;
    logic [NCH-1:0]            p;
    logic [NCH-1:0]            hit;

    assign p = pipe_q[DEPTH-1];

    // p_d_q tracks p in both modes, so entering edge mode never sees a stale edge.
    assign hit = mode_edge ? (p & ~p_d_q) : p;

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_d       = cnt_q;
        alarm_d     = alarm_q;
        alarm_any_d = |alarm_q;
        rd_cnt_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (clr) begin
                cnt_d[i]   = '0;
                alarm_d[i] = 1'b0;
            end else begin
                if (enable && hit[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                if ((thresh != '0) && (cnt_q[i] >= thresh)) begin
                    alarm_d[i] = 1'b1;
                end
            end
            // Selects outside 0..NCH-1 match nothing and read back as zero.
            if (rd_sel == SEL_W'(i)) begin
                rd_cnt_d = cnt_q[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            pipe_q      <= '0;
            p_d_q       <= '0;
            cnt_q       <= '0;
            alarm_q     <= '0;
            alarm_any_q <= 1'b0;
            rd_cnt_q    <= '0;
        end else begin
            pipe_q[0] <= trig_in;
            for (int d = 1; d < DEPTH; d++) begin
                pipe_q[d] <= pipe_q[d-1];
            end
            p_d_q       <= p;
            cnt_q       <= cnt_d;
            alarm_q     <= alarm_d;
            alarm_any_q <= alarm_any_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign rd_cnt    = rd_cnt_q;
    assign alarm     = alarm_q;
    assign alarm_any = alarm_any_q;

endmodule

// File: tb/tb_trig_activity_monitor.sv
// Bench for trig_activity_monitor: directed scenarios plus random traffic,
// all checked against a queue-based behavioural model of the channel rules.
module tb_trig_activity_monitor;

    localparam int NCH   = 3;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int SEL_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   trig_in;
    logic             mode_edge;
    logic             enable;
    logic [CNT_W-1:0] thresh;
    logic             clr;
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_cnt;
    logic [NCH-1:0]   alarm;
    logic             alarm_any;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [NCH-1:0] m_pipe[$];
    int             m_cnt[NCH];
    bit             m_alarm[NCH];
    bit             m_pd[NCH];
    bit             m_any;
    int             m_rd;

    trig_activity_monitor #(.NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .I1470_clk (clk),
        .I1477_rst (rst_n),
        .trig_in   (trig_in),
        .mode_edge (mode_edge),
        .enable    (enable),
        .thresh    (thresh),
        .clr       (clr),
        .rd_sel    (rd_sel),
        .rd_cnt    (rd_cnt),
        .alarm     (alarm),
        .alarm_any (alarm_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pipe = {};
        for (int d = 0; d < DEPTH; d++) m_pipe.push_back('0);
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]   = 0;
            m_alarm[i] = 0;
            m_pd[i]    = 0;
        end
        m_any = 0;
        m_rd  = 0;
    endtask

    function automatic logic [NCH-1:0] model_alarm_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_alarm[i];
        return v;
    endfunction

    // One rising edge of the reference: all next values come from pre-edge state.
    task automatic model_step();
        logic [NCH-1:0] p;
        bit hit;
        bit any_now;
        p = m_pipe[$];
        any_now = 0;
        for (int i = 0; i < NCH; i++) any_now |= m_alarm[i];
        m_rd  = (int'(rd_sel) < NCH) ? m_cnt[rd_sel] : 0;
        m_any = any_now;
        for (int i = 0; i < NCH; i++) begin
            hit = mode_edge ? (p[i] && !m_pd[i]) : p[i];
            if (clr) begin
                m_alarm[i] = 0;
                m_cnt[i]   = 0;
            end else begin
                if (thresh != 0 && m_cnt[i] >= int'(thresh)) m_alarm[i] = 1;
                if (enable && hit) m_cnt[i] = (m_cnt[i] + 1 > MAXC) ? MAXC : m_cnt[i] + 1;
            end
            m_pd[i] = p[i];
        end
        m_pipe.push_front(trig_in);
        void'(m_pipe.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("rd_cnt", rd_cnt, m_rd);
        check("alarm", alarm, model_alarm_vec());
        check("alarm_any", alarm_any, m_any);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int guard;

        // Reset with all triggers high: outputs must stay zero.
        rst_n = 1'b0; trig_in = '1; mode_edge = 1'b1; enable = 1'b1;
        thresh = '0; clr = 1'b0; rd_sel = '0;
        model_reset();
        #22;
        check("reset_rd_cnt", rd_cnt, 0);
        check("reset_alarm", alarm, 0);
        check("reset_alarm_any", alarm_any, 0);
        @(negedge clk); rst_n = 1'b1;
        ticks(4);
        check("edge_out_of_reset_4", rd_cnt, 1);
        ticks(3);
        check("edge_out_of_reset_hold", rd_cnt, 1);
        rd_sel = 2'd1; tick();
        check("edge_out_of_reset_ch1", rd_cnt, 1);

        // Level mode: ch0 high 10 cycles, thresh 5.
        trig_in = '0; mode_edge = 1'b0; clr = 1'b1; ticks(3);
        clr = 1'b0; thresh = 4'd5; rd_sel = 2'd0;
        trig_in = 3'b001; ticks(10);
        trig_in = '0;     ticks(5);
        check("level_cnt10", rd_cnt, 10);
        check("level_alarm0", alarm[0], 1'b1);
        check("level_alarm_any", alarm_any, 1'b1);

        // Saturation on ch1 at 15 with thresh 15.
        clr = 1'b1; tick(); clr = 1'b0;
        thresh = 4'd15; rd_sel = 2'd1;
        trig_in = 3'b010; ticks(40);
        trig_in = '0;     ticks(4);
        check("sat_cnt15", rd_cnt, 15);
        check("sat_alarm1", alarm[1], 1'b1);

        // Edge mode: ch2 pulses 1,0,1,0,1, second pulse's hit masked by enable.
        clr = 1'b1; tick(); clr = 1'b0;
        mode_edge = 1'b1; thresh = '0; rd_sel = 2'd2;
        trig_in = 3'b100; tick();
        trig_in = 3'b000; tick();
        trig_in = 3'b100; tick();
        trig_in = 3'b000; tick();
        trig_in = 3'b100; enable = 1'b0; tick();
        trig_in = 3'b000; enable = 1'b1; ticks(6);
        check("edge_cnt2", rd_cnt, 2);

        // clr coincident with a hit at cnt=3.
        clr = 1'b1; tick(); clr = 1'b0;
        mode_edge = 1'b0; thresh = 4'd2; rd_sel = 2'd0;
        trig_in = 3'b001;
        guard = 0;
        while (m_cnt[0] != 3 && guard < 20) begin tick(); guard++; end
        check("clr_reach_cnt3", guard < 20, 1);
        clr = 1'b1; trig_in = '0; tick();
        check("clr_alarm0", alarm[0], 1'b0);
        check("clr_any_lags", alarm_any, 1'b1);
        clr = 1'b0; tick();
        check("clr_cnt0", rd_cnt, 0);
        check("clr_any_falls", alarm_any, 1'b0);

        // Async reset mid-cycle at cnt=7.
        thresh = 4'd3; trig_in = 3'b001;
        guard = 0;
        while (m_rd != 7 && guard < 30) begin tick(); guard++; end
        check("arst_reach_cnt7", guard < 30, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd_cnt", rd_cnt, 0);
        check("arst_alarm", alarm, 0);
        check("arst_alarm_any", alarm_any, 0);
        model_reset();
        @(negedge clk);
        rd_sel = 2'd3; trig_in = '1; rst_n = 1'b1;
        ticks(6);
        check("rd_sel_out_of_range", rd_cnt, 0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            trig_in = NCH'($urandom);
            if ($urandom_range(0, 15) == 0) mode_edge = ~mode_edge;
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) thresh = CNT_W'($urandom_range(0, MAXC));
            clr    = ($urandom_range(0, 63) == 0);
            rd_sel = SEL_W'($urandom_range(0, 3));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trig_activity_monitor.md
Name: trig_activity_monitor

Overview:
Parametrised successor to the fixed single-output Nt-node subcircuits. Watches NCH rare internal trigger nodes, each through a DEPTH-stage register pipeline. Counts activations per channel in saturating counters and raises sticky per-channel and global alarms when a programmable threshold is reached. Sits beside benchmark subcircuits in the trojan-detection testbenches; counts are read back through a channel-select port.

Parameters:
NCH, 4, number of monitored trigger channels (1..16)
DEPTH, 2, input pipeline stages per channel before detection (1..4)
CNT_W, 8, per-channel counter width (2..16)

Ports:
I1470_clk  input  1  single clock, all flops rising-edge
I1477_rst  input  1  asynchronous active-low reset; clears every flop immediately
trig_in  input  NCH  raw trigger node values, one bit per channel
mode_edge  input  1  1 = count rising edges; 0 = count every cycle the pipelined bit is high
enable  input  1  counting enable; when 0, counters hold, pipeline keeps shifting
thresh  input  CNT_W  alarm threshold, shared by all channels, sampled every cycle
clr  input  1  synchronous clear of counters and alarms, pipeline untouched
rd_sel  input  clog2(NCH) (min 1)  channel select for readback
rd_cnt  output  CNT_W  registered count of channel rd_sel
alarm  output  NCH  sticky per-channel alarm
alarm_any  output  1  OR of alarm, registered

Behaviour:
- Reset (I1477_rst=0, async): pipelines, previous-value flops, counters, alarm, alarm_any and rd_cnt go to 0. Release is sampled on the next rising edge.
- Pipeline: trig_in[i] passes through DEPTH flops; p[i] is the last stage. p lags trig_in by DEPTH cycles.
- Detect: hit[i] = mode_edge ? (p[i] & ~p_d[i]) : p[i], where p_d is p delayed one cycle. p_d resets to 0, so a channel that is high out of reset counts one edge.
- Count: when enable=1, clr=0 and hit[i]=1, cnt[i] <= cnt[i]+1, saturating at 2^CNT_W-1. No wrap-around.
- Alarm: alarm[i] <= 1 on the cycle after cnt[i] >= thresh and thresh != 0. It stays set until clr or reset. thresh=0 disables alarming.
- alarm_any is the registered OR of the alarm vector, one cycle behind alarm.
- Clear: clr=1 sets cnt and alarm to 0 next edge. clr has priority over a simultaneous hit, so that hit is lost. alarm_any falls one cycle later.
- Mode change takes effect on the next edge. p_d keeps updating in both modes, so switching to edge mode never creates a spurious edge.
- Readback: rd_cnt <= cnt[rd_sel] every edge, one cycle latency. rd_sel >= NCH returns 0.
- Latency, trig_in rising to cnt increment visible internally: DEPTH+1 edges. Visible on rd_cnt: DEPTH+2 edges.
- Reset asserted mid-count clears everything asynchronously, with no partial state retained.

Test Plan:
- Reset: drive trig_in=all 1 with I1477_rst=0 -> all outputs 0. Release with mode_edge=1, enable=1, DEPTH=2 -> each cnt=1 and rd_cnt=1 after 4 edges, then stays 1.
- Level mode: ch0 high for 10 cycles, thresh=5 -> cnt[0]=10. alarm[0] rises on the cycle after cnt reaches 5; alarm_any follows one cycle later.
- Saturation: CNT_W=4, level mode, ch1 high for 40 cycles -> rd_cnt holds 15 with no wrap. alarm[1] is set if thresh=15.
- Edge mode: pulse ch2 as 1,0,1,0,1 with enable dropped during the 2nd pulse -> cnt[2]=2.
- clr coincident with a hit on ch0 at cnt=3 -> cnt=0 and alarm=0 next edge, hit not counted. alarm_any=0 one cycle after alarm clears.
- Async reset asserted mid-cycle at cnt=7 -> rd_cnt and alarm go 0 immediately, before the next edge. rd_sel=NCH -> rd_cnt=0.
